// File: rtl/qspi_xip_cache.sv
// Read-only direct-mapped execute-in-place cache. It sits between an AXI4-Lite read port
// and the word-burst request/data port of the QSPI flash controller.
module qspi_xip_cache #(
    parameter int          ADDR_W         = 24,
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          CNT_W          = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    input  logic [2:0]        arprot,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    input  logic              inv,
    output logic              flash_req_valid,
    input  logic              flash_req_ready,
    output logic [ADDR_W-1:0] flash_req_addr,
    output logic [7:0]        flash_req_len,
    input  logic [31:0]       flash_rdata,
    input  logic              flash_rvalid,
    output logic              flash_rready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int LO = WB + 2;
    localparam int TW = ADDR_W - LO - IB;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // A valid, once raised, stays high with its payload stable until the transfer.
    typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_DATA, RESP} state_t;
    state_t state, state_next;

    logic [31:0]          addr_q;
    logic [31:0]          off;
    logic [WB-1:0]        word;
    logic [IB-1:0]        idx;
    logic [TW-1:0]        tag;
    logic [WB-1:0]        beat_cnt;
    logic [LINES-1:0]     valid_q;
    logic                 inv_pending;
    logic [TW-1:0]        tag_mem  [LINES];
    logic [31:0]          data_mem [LINES*WORDS_PER_LINE];
    logic                 bad_addr, hit, last_beat;
    logic                 unused;

    assign off       = addr_q - BASE_ADDR;
    assign word      = off[LO-1:2];
    assign idx       = off[LO+IB-1:LO];
    assign tag       = off[ADDR_W-1:LO+IB];
    // BASE_ADDR is aligned to the window size, so the window test is an upper-bit compare.
    assign bad_addr  = (addr_q[31:ADDR_W] != BASE_ADDR[31:ADDR_W]) || (addr_q[1:0] != 2'b00);
    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign last_beat = flash_rvalid && (beat_cnt == WB'(WORDS_PER_LINE - 1));
    assign flash_req_len = 8'(WORDS_PER_LINE);
    assign unused    = ^{arprot, off[31:ADDR_W], off[1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (arvalid && arready) state_next = LOOKUP;
            LOOKUP:    state_next = (bad_addr || hit) ? RESP : FILL_REQ;
            FILL_REQ:  if (flash_req_ready) state_next = FILL_DATA;
            FILL_DATA: if (last_beat) state_next = RESP;
            RESP:      if (rready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        rvalid          = (state == RESP);
        flash_req_valid = (state == FILL_REQ);
        flash_rready    = (state == FILL_DATA);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready        <= 1'b0;
            addr_q         <= '0;
            rdata          <= '0;
            rresp          <= 2'b00;
            flash_req_addr <= '0;
            beat_cnt       <= '0;
            valid_q        <= '0;
            inv_pending    <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            // Registered so that arready stays low while reset is asserted.
            arready <= (state_next == IDLE);
            if (state == IDLE && arvalid && arready) addr_q <= araddr;
            if (state == LOOKUP) begin
                rresp <= bad_addr ? 2'b10 : 2'b00;
                if (bad_addr) begin
                    rdata <= '0;
                end else if (hit) begin
                    rdata <= data_mem[{idx, word}];
                    if (hit_count != '1) hit_count <= hit_count + 1'b1;
                end else begin
                    if (miss_count != '1) miss_count <= miss_count + 1'b1;
                    flash_req_addr <= {off[ADDR_W-1:LO], LO'(0)};
                    beat_cnt       <= '0;
                end
            end
            if (state == FILL_DATA && flash_rvalid) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == word) rdata <= flash_rdata;
            end
            // The tag compare in LOOKUP sees the pre-clear valid bits, so a same-cycle hit stands.
            if (inv)
                valid_q <= '0;
            else if (state == FILL_DATA && last_beat && !inv_pending)
                valid_q[idx] <= 1'b1;
            if (state == IDLE)
                inv_pending <= 1'b0;
            else if (inv && (state == FILL_REQ || state == FILL_DATA))
                inv_pending <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (state == FILL_DATA && flash_rvalid) begin
            data_mem[{idx, beat_cnt}] <= flash_rdata;
            if (last_beat) tag_mem[idx] <= tag;
        end
    end
endmodule

// File: tb/tb_qspi_xip_cache.sv
// Directed bench for qspi_xip_cache: an AXI read driver, a flash burst responder,
// and a queue of expected {rresp, rdata} popped at each read response.
module tb_qspi_xip_cache;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        inv = 1'b0;
    logic        flash_req_valid;
    logic        flash_req_ready = 1'b0;
    logic [23:0] flash_req_addr;
    logic [7:0]  flash_req_len;
    logic [31:0] flash_rdata = '0;
    logic        flash_rvalid = 1'b0;
    logic        flash_rready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic [33:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int req_seen = 0;
    int req_snap = 0;

    qspi_xip_cache dut (
        .aclk(aclk), .aresetn(aresetn), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arprot(arprot), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .inv(inv),
        .flash_req_valid(flash_req_valid), .flash_req_ready(flash_req_ready),
        .flash_req_addr(flash_req_addr), .flash_req_len(flash_req_len),
        .flash_rdata(flash_rdata), .flash_rvalid(flash_rvalid), .flash_rready(flash_rready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;
    always @(posedge aclk) if (flash_req_valid) req_seen++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] data);
        exp_q.push_back({resp, data});
        @(negedge aclk);
        arvalid = 1'b1;
        araddr  = a;
        for (int i = 0; i < 50; i++) begin
            if (arready) break;
            @(negedge aclk);
        end
        chk("arready", arready, 1);
        hs_cyc = cyc;
        @(posedge aclk);
        #1 arvalid = 1'b0;
    endtask

    task automatic fill(input logic [23:0] la, input logic [31:0] d0, input int inv_beat, input int stop_beat);
        @(negedge aclk);
        for (int i = 0; i < 50; i++) begin
            if (flash_req_valid) break;
            @(negedge aclk);
        end
        chk("req_valid", flash_req_valid, 1);
        chk("req_addr", flash_req_addr, la);
        chk("req_len", flash_req_len, 4);
        flash_req_ready = 1'b1;
        @(posedge aclk);
        #1 flash_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == stop_beat) break;
            @(negedge aclk);
            if (b == 0) chk("rready_fill", flash_rready, 1);
            flash_rvalid = 1'b1;
            flash_rdata  = d0 + 32'(b);
            inv          = (b == inv_beat);
            @(posedge aclk);
            #1;
            flash_rvalid = 1'b0;
            inv          = 1'b0;
        end
    endtask

    task automatic get_resp(input int stall, input bit lat_chk);
        logic [33:0] e;
        e = 'x;
        @(negedge aclk);
        for (int i = 0; i < 50; i++) begin
            if (rvalid) break;
            @(negedge aclk);
        end
        chk("rvalid", rvalid, 1);
        if (lat_chk) chk("hit_latency", 64'(cyc - hs_cyc), 2);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("rdata", rdata, e[31:0]);
        chk("rresp", rresp, e[33:32]);
        for (int s = 0; s < stall; s++) begin
            @(negedge aclk);
            chk("stall_rvalid", rvalid, 1);
            chk("stall_rdata", rdata, e[31:0]);
            chk("stall_rresp", rresp, e[33:32]);
            chk("stall_arready", arready, 0);
        end
        rready = 1'b1;
        @(posedge aclk);
        #1 rready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_arready"}, arready, 0);
        chk({pfx, "_rvalid"}, rvalid, 0);
        chk({pfx, "_rdata"}, rdata, 0);
        chk({pfx, "_rresp"}, rresp, 0);
        chk({pfx, "_req_valid"}, flash_req_valid, 0);
        chk({pfx, "_flash_rready"}, flash_rready, 0);
        chk({pfx, "_req_addr"}, flash_req_addr, 0);
        chk({pfx, "_hits"}, hit_count, 0);
        chk({pfx, "_misses"}, miss_count, 0);
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        chk_reset_outputs("reset");
        aresetn = 1'b1;

        // Cold miss: word 1 of line 0x000100.
        do_ar(32'h1000_0104, 2'b00, 32'hA1);
        fill(24'h000100, 32'hA0, -1, 4);
        get_resp(0, 0);
        chk("miss_cold", miss_count, 1);
        chk("hit_cold", hit_count, 0);

        // Hit on the same line, no flash traffic.
        req_snap = req_seen;
        do_ar(32'h1000_010C, 2'b00, 32'hA3);
        get_resp(0, 1);
        chk("hit_after", hit_count, 1);
        chk("no_req_hit", 64'(req_seen), 64'(req_snap));

        // Same-index replacement, then the evicted line misses again.
        do_ar(32'h1000_1100, 2'b00, 32'hB0);
        fill(24'h001100, 32'hB0, -1, 4);
        get_resp(0, 0);
        do_ar(32'h1000_0104, 2'b00, 32'hC1);
        fill(24'h000100, 32'hC0, -1, 4);
        get_resp(0, 0);
        chk("miss_evict", miss_count, 3);

        // Out-of-window and misaligned reads.
        req_snap = req_seen;
        do_ar(32'h0FFF_FFFC, 2'b10, 32'h0);
        get_resp(0, 0);
        do_ar(32'h1000_0102, 2'b10, 32'h0);
        get_resp(0, 0);
        do_ar(32'h1100_0000, 2'b10, 32'h0);
        get_resp(0, 0);
        chk("err_hits", hit_count, 1);
        chk("err_misses", miss_count, 3);
        chk("no_req_err", 64'(req_seen), 64'(req_snap));

        // Invalidate during beat 2: data still correct, line not kept.
        do_ar(32'h1000_0208, 2'b00, 32'hD2);
        fill(24'h000200, 32'hD0, 2, 4);
        get_resp(0, 0);
        do_ar(32'h1000_0208, 2'b00, 32'hE2);
        fill(24'h000200, 32'hE0, -1, 4);
        get_resp(0, 0);
        chk("miss_inv", miss_count, 5);

        // Back-pressured hit response.
        do_ar(32'h1000_020C, 2'b00, 32'hE3);
        get_resp(5, 0);
        chk("hit_stall", hit_count, 2);

        // Reset in the middle of a line fill.
        do_ar(32'h1000_0300, 2'b00, 32'h0);
        fill(24'h000300, 32'h90, -1, 2);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("midfill");
        exp_q.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        do_ar(32'h1000_020C, 2'b00, 32'hF3);
        fill(24'h000200, 32'hF0, -1, 4);
        get_resp(0, 0);
        chk("miss_after_rst", miss_count, 1);
        chk("hit_after_rst", hit_count, 0);
        chk("sb_empty", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/qspi_xip_cache.md
Name: qspi_xip_cache

Overview:
Parametrised read-only execute-in-place cache that sits between an AXI4-Lite read slave port and the team's QSPI flash controller request/data interface. Successor to the fixed single-configuration SPI cache: configurable line count, line length and flash address width, plus an address-window check, a misalignment check, a global invalidate and hit/miss statistics. The QSPI pin-level controller stays outside this block. The block talks only to that controller's word-burst request port.

Parameters:
ADDR_W, 24, flash byte-address width; flash_req_addr width.
LINES, 16, number of direct-mapped lines; power of two, >=2.
WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2.
BASE_ADDR, 32'h1000_0000, AXI address of flash byte 0; aligned to 2^ADDR_W.
CNT_W, 32, width of hit/miss counters.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arvalid  in  1  AXI read-address valid
arready  out  1  AXI read-address ready
araddr  in  32  AXI read address
arprot  in  3  ignored
rvalid  out  1  AXI read-data valid
rready  in  1  AXI read-data ready
rdata  out  32  AXI read data
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
inv  in  1  single-cycle pulse: invalidate all lines
flash_req_valid  out  1  line-fill request valid
flash_req_ready  in  1  controller accepts request
flash_req_addr  out  ADDR_W  line-aligned flash byte address
flash_req_len  out  8  words in burst (= WORDS_PER_LINE)
flash_rdata  in  32  burst data word
flash_rvalid  in  1  burst data valid
flash_rready  out  1  cache accepts burst word
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split, with off = araddr - BASE_ADDR: word = off[log2(WPL)+1:2]; index = next log2(LINES) bits; tag = remaining bits up to ADDR_W-1. Defaults give 2 word bits, 4 index bits and a 16-bit tag.
- Reset: arready=0, rvalid=0, rdata=0, rresp=0, flash_req_valid=0, flash_rready=0, flash_req_addr=0, all valid bits=0, counters=0, state=IDLE.
- FSM states: IDLE, LOOKUP, FILL_REQ, FILL_DATA, RESP.
- IDLE: arready=1. On arvalid&arready, register the address and go to LOOKUP.
- LOOKUP:
  - Address outside [BASE_ADDR, BASE_ADDR+2^ADDR_W) or araddr[1:0]!=0: rresp=2'b10, rdata=0, go to RESP. No counter change.
  - Hit (valid && tag match): rdata=word, rresp=0, hit_count++, go to RESP. Hit latency: AR handshake at cycle N gives rvalid at N+2.
  - Miss: miss_count++, go to FILL_REQ.
- FILL_REQ: flash_req_valid=1, flash_req_addr = line-aligned off[ADDR_W-1:0], flash_req_len=WORDS_PER_LINE. Address and length are held stable until flash_req_ready. On handshake, go to FILL_DATA.
- FILL_DATA: flash_rready=1. Each flash_rvalid beat writes word[beat_cnt], where beat_cnt runs 0..WPL-1. The requested word is captured into rdata when beat_cnt equals its word offset. After the last beat: write tag, set valid (unless an invalidate is pending), go to RESP.
- RESP: rvalid=1. rdata and rresp are held until rready. On rvalid&rready, go to IDLE. The next AR handshake is possible no earlier than the following cycle, so there is one outstanding read max.
- inv: clears all valid bits in the cycle it is sampled, in any state.
  - inv during FILL_REQ or FILL_DATA sets inv_pending. That fill still returns correct data but its line is NOT marked valid. inv_pending clears on return to IDLE.
  - inv in LOOKUP on the same cycle as a hit: the hit stands (tag compare uses the pre-clear state).
- Same-index line replacement on a miss overwrites the line. No write path exists.
- Counters saturate at all-ones. They do not wrap.
- Asynchronous reset mid-fill aborts immediately to IDLE. The flash controller shares aresetn and is reset with it. No partial line is left valid.
- flash_rvalid outside FILL_DATA is ignored (flash_rready=0).

Test Plan:
1. Cold read 0x1000_0104 → flash_req_addr=24'h000100, len=4. Feed beats 0xA0,0xA1,0xA2,0xA3 → rdata=0xA1, rresp=0, miss_count=1.
2. Next read 0x1000_010C → hit, rvalid 2 cycles after AR handshake, rdata=0xA3, hit_count=1, no flash_req_valid.
3. Read 0x1000_1100 (same index 0, tag 0x0011) → new fill at 24'h001100. Then re-reading 0x1000_0104 misses again (miss_count=3).
4. Read 0x0FFF_FFFC and 0x1000_0102 → rresp=2'b10, rdata=0, no flash request, counters unchanged.
5. Pulse inv during beat 2 of a fill → correct rdata returned. An immediate re-read of the same address misses and refills.
6. Hold rready=0 for 5 cycles in RESP → rvalid, rdata, rresp stable and arready=0 throughout. Assert aresetn low mid-FILL_DATA → all outputs reach reset values, and a later read of that line misses.
